// File: rtl/cv32e40p_fetch_fifo_ft.sv
// Prefetch FIFO with triplicated, majority-voted control state (wptr/rptr/cnt), FWFT to the aligner.
// Latency: word pushed at edge N is visible on out_rdata_o after edge N; no same-cycle bypass.
// Backpressure: in_ready_o drops when the voted count reaches DEPTH; a pop in the same cycle does not free a slot.
module cv32e40p_fetch_fifo_ft #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_rdata_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_rdata_o,
    input  logic                  out_ready_i,
    input  logic                  flush_i,
    input  logic [2:0]            inject_i,
    output logic                  err_detected_o,
    output logic                  err_corrected_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
    logic [AW-1:0]         wptr_q [3];
    logic [AW-1:0]         rptr_q [3];
    logic [CW-1:0]         cnt_q  [3];

    logic [AW-1:0] v_wptr, v_rptr, wptr_d, rptr_d;
    logic [CW-1:0] v_cnt, cnt_d;
    logic          not_full, not_empty, push, pop, push_eff, uncorrectable, clear;
    logic          diff_w, diff_r, diff_c, pair_w, pair_r, pair_c;

    assign v_wptr = (wptr_q[0] & wptr_q[1]) | (wptr_q[0] & wptr_q[2]) | (wptr_q[1] & wptr_q[2]);
    assign v_rptr = (rptr_q[0] & rptr_q[1]) | (rptr_q[0] & rptr_q[2]) | (rptr_q[1] & rptr_q[2]);
    assign v_cnt  = (cnt_q[0] & cnt_q[1])   | (cnt_q[0] & cnt_q[2])   | (cnt_q[1] & cnt_q[2]);

    assign diff_w = !((wptr_q[0] == wptr_q[1]) && (wptr_q[1] == wptr_q[2]));
    assign diff_r = !((rptr_q[0] == rptr_q[1]) && (rptr_q[1] == rptr_q[2]));
    assign diff_c = !((cnt_q[0] == cnt_q[1]) && (cnt_q[1] == cnt_q[2]));
    assign pair_w = (wptr_q[0] == wptr_q[1]) || (wptr_q[0] == wptr_q[2]) || (wptr_q[1] == wptr_q[2]);
    assign pair_r = (rptr_q[0] == rptr_q[1]) || (rptr_q[0] == rptr_q[2]) || (rptr_q[1] == rptr_q[2]);
    assign pair_c = (cnt_q[0] == cnt_q[1]) || (cnt_q[0] == cnt_q[2]) || (cnt_q[1] == cnt_q[2]);

    assign err_detected_o  = diff_w | diff_r | diff_c;
    assign err_corrected_o = err_detected_o & pair_w & pair_r & pair_c;
    // Three-way disagreement leaves the vote untrustworthy, so the contents are dropped.
    assign uncorrectable   = err_detected_o & ~err_corrected_o;
    assign clear           = flush_i | uncorrectable;

    assign not_full    = (v_cnt != CW'(DEPTH));
    assign not_empty   = (v_cnt != '0);
    assign in_ready_o  = not_full;
    assign out_valid_o = not_empty;
    assign out_rdata_o = mem_q[v_rptr];

    assign push     = in_valid_i & not_full;
    assign pop      = not_empty & out_ready_i;
    assign push_eff = push & ~clear;

    always_comb begin
        wptr_d = v_wptr;
        rptr_d = v_rptr;
        cnt_d  = v_cnt;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = v_wptr + AW'(1);
            if (pop)  rptr_d = v_rptr + AW'(1);
            cnt_d = v_cnt + CW'(push) - CW'(pop);
        end
    end

    // All copies reload from the voted next state, scrubbing any single upset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                wptr_q[k] <= wptr_d;
                rptr_q[k] <= rptr_d;
                cnt_q[k]  <= cnt_d ^ (CW'(inject_i[k]) << k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_eff) begin
            mem_q[v_wptr] <= in_rdata_i;
        end
    end
endmodule

// File: tb/tb_cv32e40p_fetch_fifo_ft.sv
// Bench for cv32e40p_fetch_fifo_ft: queue-based reference model checked every cycle, plus directed literal checks.
module tb_cv32e40p_fetch_fifo_ft;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic [31:0] in_rdata_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_rdata_o;
    logic        out_ready_i;
    logic        flush_i;
    logic [2:0]  inject_i;
    logic        err_detected_o;
    logic        err_corrected_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] q[$];
    int          c[3];

    cv32e40p_fetch_fifo_ft #(.DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid_i      (in_valid_i),
        .in_rdata_i      (in_rdata_i),
        .in_ready_o      (in_ready_o),
        .out_valid_o     (out_valid_o),
        .out_rdata_o     (out_rdata_o),
        .out_ready_i     (out_ready_i),
        .flush_i         (flush_i),
        .inject_i        (inject_i),
        .err_detected_o  (err_detected_o),
        .err_corrected_o (err_corrected_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int vote_cnt();
        return (c[0] & c[1]) | (c[0] & c[2]) | (c[1] & c[2]);
    endfunction

    function automatic bit model_det();
        return !(c[0] == c[1] && c[1] == c[2]);
    endfunction

    function automatic bit model_corr();
        return model_det() && (c[0] == c[1] || c[0] == c[2] || c[1] == c[2]);
    endfunction

    // Advance the reference model by one clock edge using the inputs held across it.
    function automatic void model_step();
        int  occ;
        bit  ir, ov, pu, po, unc;
        occ = vote_cnt();
        ir  = (occ != DEPTH);
        ov  = (occ != 0);
        pu  = in_valid_i && ir;
        po  = ov && out_ready_i;
        unc = model_det() && !model_corr();
        if (flush_i || unc) begin
            q.delete();
        end else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back(in_rdata_i);
        end
        for (int k = 0; k < 3; k++)
            c[k] = q.size() ^ (inject_i[k] ? (1 << k) : 0);
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("m_out_valid", {31'b0, out_valid_o}, {31'b0, vote_cnt() != 0});
            check("m_in_ready",  {31'b0, in_ready_o},  {31'b0, vote_cnt() != DEPTH});
            check("m_err_det",   {31'b0, err_detected_o},  {31'b0, model_det()});
            check("m_err_corr",  {31'b0, err_corrected_o}, {31'b0, model_corr()});
            if (q.size() > 0) check("m_rdata", out_rdata_o, q[0]);
        end
    end

    task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic [2:0] inj);
        in_valid_i  = iv;
        in_rdata_i  = d;
        out_ready_i = ordy;
        flush_i     = fl;
        inject_i    = inj;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic pop();
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp4[4];
        logic [31:0] w;
        exp4 = '{32'h11, 32'h22, 32'h33, 32'h44};

        rst_n = 1'b0; in_valid_i = 1'b0; in_rdata_i = '0; out_ready_i = 1'b0;
        flush_i = 1'b0; inject_i = 3'b000;
        q.delete(); c = '{0, 0, 0};
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready_o},  32'd1);
        check("rst_rdata",     out_rdata_o,          32'd0);
        check("rst_err_det",   {31'b0, err_detected_o},  32'd0);
        check("rst_err_corr",  {31'b0, err_corrected_o}, 32'd0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Fill, then a rejected fifth word
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        check("full_in_ready",  {31'b0, in_ready_o},  32'd0);
        check("full_out_valid", {31'b0, out_valid_o}, 32'd1);
        check("full_rdata",     out_rdata_o,          32'h11);
        push(32'h55);
        check("reject_in_ready", {31'b0, in_ready_o}, 32'd0);
        check("reject_rdata",    out_rdata_o,         32'h11);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            check("drain_rdata", out_rdata_o, exp4[i]);
            pop();
        end
        check("drain_empty", {31'b0, out_valid_o}, 32'd0);

        // Streaming through pointer wrap
        push(32'h101);
        check("wrap_rdata0", out_rdata_o, 32'h101);
        for (int i = 1; i < 6; i++) begin
            w = 32'h101 + 32'(i);
            cyc(1'b1, w, 1'b1, 1'b0, 3'b000);
            check("wrap_rdata", out_rdata_o, w);
        end
        pop();
        check("wrap_empty", {31'b0, out_valid_o}, 32'd0);

        // Single-copy upset: corrected and scrubbed
        push(32'h11); push(32'h22);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 3'b001);
        check("seu_det",   {31'b0, err_detected_o},  32'd1);
        check("seu_corr",  {31'b0, err_corrected_o}, 32'd1);
        check("seu_valid", {31'b0, out_valid_o},     32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 3'b000);
        check("scrub_det",  {31'b0, err_detected_o},  32'd0);
        check("scrub_corr", {31'b0, err_corrected_o}, 32'd0);
        check("scrub_rdata", out_rdata_o, 32'h11);
        pop();
        check("scrub_rdata2", out_rdata_o, 32'h22);
        pop();
        check("scrub_empty", {31'b0, out_valid_o}, 32'd0);

        // Double upset: copies 3,0,2 -> uncorrectable, forced empty, push dropped
        push(32'h11); push(32'h22);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 3'b011);
        check("dbl_det",   {31'b0, err_detected_o},  32'd1);
        check("dbl_corr",  {31'b0, err_corrected_o}, 32'd0);
        check("dbl_valid", {31'b0, out_valid_o},     32'd1);
        cyc(1'b1, 32'h99, 1'b0, 1'b0, 3'b000);
        check("dbl_flush_valid", {31'b0, out_valid_o}, 32'd0);
        check("dbl_flush_ready", {31'b0, in_ready_o},  32'd1);
        check("dbl_flush_det",   {31'b0, err_detected_o},  32'd0);
        check("dbl_flush_corr",  {31'b0, err_corrected_o}, 32'd0);

        // Flush beats simultaneous push and pop
        push(32'h51); push(32'h52); push(32'h53);
        cyc(1'b1, 32'hBB, 1'b1, 1'b1, 3'b000);
        check("flush_valid", {31'b0, out_valid_o}, 32'd0);
        check("flush_ready", {31'b0, in_ready_o},  32'd1);
        push(32'hAA);
        check("post_flush_rdata", out_rdata_o, 32'hAA);
        check("post_flush_valid", {31'b0, out_valid_o}, 32'd1);
        pop();
        check("post_flush_empty", {31'b0, out_valid_o}, 32'd0);

        // Asynchronous reset mid-cycle
        push(32'h61); push(32'h62);
        in_valid_i = 1'b0;
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        q.delete(); c = '{0, 0, 0};
        #1;
        check("arst_valid", {31'b0, out_valid_o}, 32'd0);
        check("arst_ready", {31'b0, in_ready_o},  32'd1);
        check("arst_rdata", out_rdata_o,          32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 3'b000);
        check("arst_after_valid", {31'b0, out_valid_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
